pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//  Shares one physical-memory port between a split instruction cache and data
//  cache (both 128-bit line, 16-bit address, cache-side pmem protocol).
//  Grants one requester at a time, forwards its line read/write to pmem, and
//  steers pmem_resp/pmem_rdata back to the granted requester. Ties are broken
//  round-robin. Sits between the two cache instances and physical memory.
// PARAMETERS
//  ADDR_WIDTH  16   address width on all ports
//  LINE_WIDTH  128  cache line / pmem data width
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           synchronous reset, active-high
//  i_pmem_read    in   1           icache line read request
//  i_pmem_write   in   1           icache line write request
//  i_pmem_address in   ADDR_WIDTH  icache line address
//  i_pmem_wdata   in   LINE_WIDTH  icache write line
//  i_pmem_rdata   out  LINE_WIDTH  read line to icache
//  i_pmem_resp    out  1           completion to icache
//  d_pmem_read    in   1           dcache line read request
//  d_pmem_write   in   1           dcache line write request
//  d_pmem_address in   ADDR_WIDTH  dcache line address
//  d_pmem_wdata   in   LINE_WIDTH  dcache write line
//  d_pmem_rdata   out  LINE_WIDTH  read line to dcache
//  d_pmem_resp    out  1           completion to dcache
//  pmem_read      out  1           read strobe to memory
//  pmem_write     out  1           write strobe to memory
//  pmem_address   out  ADDR_WIDTH  address to memory
//  pmem_wdata     out  LINE_WIDTH  write line to memory
//  pmem_rdata     in   LINE_WIDTH  read line from memory
//  pmem_resp      in   1           memory completion
// BEHAVIOUR
//  - Requests are level-held: a requester keeps read/write/address/wdata stable
//    until it sees its resp; arbiter does not latch address/data.
//  - req_i = i_pmem_read|i_pmem_write; req_d likewise. Read and write high
//    together from one requester is treated as write.
//  - FSM states: IDLE, SERVE_I, SERVE_D. Register last_grant (I/D).
//  - IDLE: no req -> IDLE. Only req_i -> SERVE_I. Only req_d -> SERVE_D.
//    Both -> serve the one not equal to last_grant.
//  - Entering SERVE_x updates last_grant <= x.
//  - SERVE_x: pmem_read/write/address/wdata = requester x's signals (comb.);
//    x_pmem_resp = pmem_resp; x_pmem_rdata = pmem_rdata. Other requester's resp
//    is 0. On pmem_resp=1 -> IDLE; else stay.
//  - Mandatory IDLE cycle after every completion: gives requester one cycle to
//    drop/renew its request; no back-to-back grant without passing IDLE.
//  - In IDLE: pmem_read=pmem_write=0, both resps 0, pmem_address/wdata = 0;
//    pmem_resp seen in IDLE is ignored.
//  - Latency: request first seen at edge N -> pmem strobe high during cycle N+1;
//    requester resp same cycle as pmem_resp (zero added return latency).
//  - Fairness: with both requesting continuously, grants strictly alternate
//    I,D,I,D...; neither waits more than one full transaction.
//  - x_pmem_rdata = pmem_rdata whenever x is granted, 0 otherwise.
//  - Reset: state<=IDLE, last_grant<=I (so first tie goes to D); all outputs
//    0 from the cycle after rst sampled high. Reset mid-transaction abandons
//    it: strobes drop, no resp is forwarded; memory must tolerate abort.
//  - A requester dropping its request mid-SERVE (protocol violation) is not
//    handled: the FSM stays in SERVE until pmem_resp.
// TESTING
//  - Reset: rst=1 2 cycles with random inputs -> all outputs 0, state IDLE.
//  - I only: i_read, addr 0x1230, pmem_resp after 5 cycles with rdata=0xA5..
//    -> pmem_read 1 cycle after req, addr 0x1230, i_resp 1 cycle, i_rdata
//    0xA5.., d_resp 0.
//  - Tie: both read at same edge after reset -> D served first (addr 0x4560),
//    then IDLE 1 cycle, then I served; grant order D,I,D,I over 4 transactions.
//  - D write: d_write, addr 0x0F00, wdata 0xDEAD..BEEF -> pmem_write=1,
//    pmem_wdata matches, pmem_read=0; d_resp on pmem_resp.
//  - Read+write both high from I -> pmem_write=1, pmem_read=0.
//  - Reset mid-SERVE_D (cycle 3 of 6) -> strobes 0 next cycle; later
//    pmem_resp not forwarded; next tie grants D again.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Arbitrates one pmem port between icache and dcache, round-robin on ties.
// Latency: grant one cycle after request seen; resp/rdata returned combinationally.
// Backpressure: loser holds its level request; one mandatory IDLE cycle between grants.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic                  i_pmem_write,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    logic   req_i, req_d;

    assign req_i = i_pmem_read | i_pmem_write;
    assign req_d = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = '0;
        pmem_wdata     = '0;
        i_pmem_resp    = 1'b0;
        i_pmem_rdata   = '0;
        d_pmem_resp    = 1'b0;
        d_pmem_rdata   = '0;
        case (state)
            IDLE: begin
                // On a tie, serve whichever side did not win last time.
                if (req_i && req_d) begin
                    if (last_grant == GRANT_I) begin
                        state_nxt      = SERVE_D;
                        last_grant_nxt = GRANT_D;
                    end else begin
                        state_nxt      = SERVE_I;
                        last_grant_nxt = GRANT_I;
                    end
                end else if (req_i) begin
                    state_nxt      = SERVE_I;
                    last_grant_nxt = GRANT_I;
                end else if (req_d) begin
                    state_nxt      = SERVE_D;
                    last_grant_nxt = GRANT_D;
                end
            end
            SERVE_I: begin
                // Read and write together from one side is treated as a write.
                pmem_write   = i_pmem_write;
                pmem_read    = i_pmem_read & ~i_pmem_write;
                pmem_address = i_pmem_address;
                pmem_wdata   = i_pmem_wdata;
                i_pmem_resp  = pmem_resp;
                i_pmem_rdata = pmem_rdata;
                if (pmem_resp) state_nxt = IDLE;
            end
            SERVE_D: begin
                pmem_write   = d_pmem_write;
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                d_pmem_rdata = pmem_rdata;
                if (pmem_resp) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed and randomized checks of pmem_arbiter against a request-level grant model.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic [15:0]  i_pmem_address, d_pmem_address, pmem_address;
    logic [127:0] i_pmem_wdata, d_pmem_wdata, pmem_wdata;
    logic [127:0] i_pmem_rdata, d_pmem_rdata, pmem_rdata;
    logic         i_pmem_resp, d_pmem_resp;
    logic         pmem_read, pmem_write, pmem_resp;

    pmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
        .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Requester model: index 0 = icache, 1 = dcache.
    logic         rd_q[2];
    logic         wr_q[2];
    logic [15:0]  addr_q[2];
    logic [127:0] wd_q[2];
    bit           pend[2];
    int           last;
    int           order[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        i_pmem_read    = pend[0] & rd_q[0];
        i_pmem_write   = pend[0] & wr_q[0];
        i_pmem_address = addr_q[0];
        i_pmem_wdata   = wd_q[0];
        d_pmem_read    = pend[1] & rd_q[1];
        d_pmem_write   = pend[1] & wr_q[1];
        d_pmem_address = addr_q[1];
        d_pmem_wdata   = wd_q[1];
    endtask

    task automatic set_req(input int who, input logic [1:0] op, input logic [15:0] a,
                           input logic [127:0] wd);
        pend[who]   = 1'b1;
        rd_q[who]   = op[0];
        wr_q[who]   = op[1];
        addr_q[who] = a;
        wd_q[who]   = wd;
    endtask

    // Round-robin rule: a lone requester wins; on a tie the side not served last wins.
    function automatic int pick();
        if (pend[0] && pend[1]) return (last == 0) ? 1 : 0;
        return pend[0] ? 0 : 1;
    endfunction

    function automatic logic own_resp(input int who);
        return (who == 0) ? i_pmem_resp : d_pmem_resp;
    endfunction
    function automatic logic oth_resp(input int who);
        return (who == 0) ? d_pmem_resp : i_pmem_resp;
    endfunction
    function automatic logic [127:0] own_rdata(input int who);
        return (who == 0) ? i_pmem_rdata : d_pmem_rdata;
    endfunction
    function automatic logic [127:0] oth_rdata(input int who);
        return (who == 0) ? d_pmem_rdata : i_pmem_rdata;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Entered at a negedge with the arbiter idle and requests applied.
    task automatic serve(input int who, input int delay, input logic [127:0] rdat);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk("grant_write", 128'(pmem_write), 128'(wr_q[who]));
        chk("grant_read", 128'(pmem_read), 128'(rd_q[who] & ~wr_q[who]));
        chk("grant_addr", 128'(pmem_address), 128'(addr_q[who]));
        chk("grant_wdata", pmem_wdata, wd_q[who]);
        chk("early_resp", 128'({own_resp(who), oth_resp(who)}), 128'(0));
        repeat (delay) @(negedge clk);
        #1;
        chk("held_addr", 128'(pmem_address), 128'(addr_q[who]));
        pmem_rdata = rdat;
        pmem_resp  = 1'b1;
        #1;
        chk("own_resp", 128'(own_resp(who)), 128'(1));
        chk("own_rdata", own_rdata(who), rdat);
        chk("other_resp", 128'(oth_resp(who)), 128'(0));
        chk("other_rdata", oth_rdata(who), 128'(0));
        order.push_back(who);
        last = who;
        pend[who] = 1'b0;
        @(negedge clk);
        apply();
        pmem_rdata = rnd128();
        pmem_resp  = 1'($urandom);
        #1;
        chk("idle_strobes", 128'({pmem_read, pmem_write}), 128'(0));
        chk("idle_addr", 128'(pmem_address), 128'(0));
        chk("idle_resp", 128'({i_pmem_resp, d_pmem_resp}), 128'(0));
    endtask

    task automatic drain();
        apply();
        pmem_resp = 1'b0;
        while (pend[0] || pend[1]) serve(pick(), $urandom_range(0, 3), rnd128());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_pmem_read = 1'($urandom); i_pmem_write = 1'($urandom);
        d_pmem_read = 1'($urandom); d_pmem_write = 1'($urandom);
        i_pmem_address = 16'($urandom); d_pmem_address = 16'($urandom);
        i_pmem_wdata = rnd128(); d_pmem_wdata = rnd128();
        pmem_rdata = rnd128(); pmem_resp = 1'($urandom);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_strobes", 128'({pmem_read, pmem_write}), 128'(0));
        chk("rst_addr", 128'(pmem_address), 128'(0));
        chk("rst_wdata", pmem_wdata, 128'(0));
        chk("rst_resp", 128'({i_pmem_resp, d_pmem_resp}), 128'(0));
        chk("rst_rdata", i_pmem_rdata | d_pmem_rdata, 128'(0));
        rst = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        last = 0;
        pmem_resp = 1'b0;
        apply();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0; rd_q[k] = 1'b0; wr_q[k] = 1'b0;
            addr_q[k] = '0; wd_q[k] = '0;
        end
        last = 0;
        apply();

        do_reset();

        // Icache-only read, response after 5 cycles.
        set_req(0, 2'b01, 16'h1230, rnd128());
        apply();
        serve(0, 4, {16{8'hA5}});

        // Simultaneous reads right after reset: D, I, D, I.
        do_reset();
        order.delete();
        for (int r = 0; r < 2; r++) begin
            set_req(0, 2'b01, 16'h7890, rnd128());
            set_req(1, 2'b01, 16'h4560, rnd128());
            drain();
        end
        chk("tie_order", 128'({order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}),
            128'(8'b01_00_01_00));

        // Dcache write.
        set_req(1, 2'b10, 16'h0F00, {32'hDEAD_0000, 64'h0123_4567_89AB_CDEF, 32'h0000_BEEF});
        drain();

        // Icache read+write together is a write.
        set_req(0, 2'b11, 16'h2468, rnd128());
        drain();

        // Reset in the middle of a dcache transaction.
        do_reset();
        set_req(1, 2'b01, 16'h3333, rnd128());
        apply();
        @(negedge clk);
        #1;
        chk("abort_pre_read", 128'(pmem_read), 128'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_strobes", 128'({pmem_read, pmem_write}), 128'(0));
        rst = 1'b0;
        pend[1] = 1'b0;
        last = 0;
        apply();
        @(negedge clk);
        pmem_resp = 1'b1;
        pmem_rdata = rnd128();
        #1;
        chk("abort_resp", 128'({i_pmem_resp, d_pmem_resp}), 128'(0));
        chk("abort_rdata", d_pmem_rdata, 128'(0));
        @(negedge clk);
        pmem_resp = 1'b0;
        order.delete();
        set_req(0, 2'b01, 16'h1111, rnd128());
        set_req(1, 2'b01, 16'h2222, rnd128());
        drain();
        chk("post_abort_first", 128'(order[0]), 128'(1));

        // Randomized rounds of mixed requests.
        for (int r = 0; r < 40; r++) begin
            int pat;
            pat = $urandom_range(1, 3);
            for (int k = 0; k < 2; k++)
                if (pat[k]) set_req(k, 2'($urandom_range(1, 3)), 16'($urandom), rnd128());
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
